pll_reconfig_sequencer: RTL and testbench

- Run-time video-mode switcher for the HDMI pixel-clock PLL (Cyclone V altera_pll, reconfigurable subtype).
- On request, writes a stored N/M/C counter set for one of NUM_MODES modes into the PLL reconfiguration controller over its Avalon-MM management port, triggers the reconfig, polls for completion, then waits for a stable PLL lock.
- Sits between the mode-select logic and the reconfig controller, which is wired to the PLL's reconfig_to_pll/reconfig_from_pll buses.

---
 rtl/pll_reconfig_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
//   Run-time video-mode switcher for a reconfigurable Cyclone V PLL. On a
//   mode request it writes the stored N/M/C counter set into the PLL
//   reconfiguration controller (Avalon-MM management port), starts the
//   reconfig, polls for completion and then waits for a stable lock.
//
//   Optional build macro: PLL_RECONFIG_LOCK_RETRY_EN
//     defined   - a lock timeout pulses pll_rst for 8 cycles and retries once
//     undefined - pll_rst is tied low, no retry
//
// Ports
//   refclk, rst         management clock, synchronous active-high reset
//   mode_sel, mode_req  requested mode and one-cycle request strobe
//   pll_locked          PLL lock (already in the refclk domain)
//   busy, done, error   status: in progress / completion pulse / sticky fail
//   current_mode        last mode applied successfully
//   pll_rst             PLL reset (retry build only, otherwise 0)
//   mgmt_*              Avalon-MM master to the reconfig controller
module pll_reconfig_sequencer #(
    parameter int NUM_MODES  = 4,
    parameter int NUM_CLOCKS = 1,
    localparam int MSEL_W    = $clog2(NUM_MODES),
    parameter logic [NUM_MODES*18-1:0]            N_TABLE = {NUM_MODES{18'h20302}},
    parameter logic [NUM_MODES*18-1:0]            M_TABLE = {NUM_MODES{18'h01212}},
    parameter logic [NUM_MODES*NUM_CLOCKS*18-1:0] C_TABLE = {NUM_MODES*NUM_CLOCKS{18'h00202}},
    parameter int LOCK_STABLE = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [MSEL_W-1:0] mode_sel,
    input  logic              mode_req,
    input  logic              pll_locked,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MSEL_W-1:0] current_mode,
    output logic              pll_rst,
    output logic [5:0]        mgmt_address,
    output logic              mgmt_write,
    output logic              mgmt_read,
    output logic [31:0]       mgmt_writedata,
    input  logic [31:0]       mgmt_readdata,
    input  logic              mgmt_waitrequest
);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_START, S_POLL, S_WAIT_LOCK,
`ifdef PLL_RECONFIG_LOCK_RETRY_EN
        S_RESET_PLL,
`endif
        S_OK, S_FAIL
    } state_t;

    state_t            state, state_d;
    logic [MSEL_W-1:0] mode_q;
    logic [4:0]        clk_idx;
    logic [16:0]       tmo_cnt;
    logic [SW-1:0]     stab_cnt;
    logic              xfer, tmo_exp, lock_ok, last_clk, bad_mode, skip_req;
    logic [17:0]       n_entry, m_entry, c_entry;
    logic              unused_rdata;

    assign unused_rdata = ^mgmt_readdata[31:1];

    // A transfer completes in the first strobe cycle without waitrequest.
    assign xfer     = (mgmt_write | mgmt_read) & ~mgmt_waitrequest;
    assign tmo_exp  = tmo_cnt >= 17'(TIMEOUT - 1);
    assign lock_ok  = pll_locked && (stab_cnt == SW'(LOCK_STABLE - 1));
    assign last_clk = clk_idx == 5'(NUM_CLOCKS - 1);
    assign bad_mode = 32'(mode_sel) >= NUM_MODES;
    // Same mode is a no-op only if the last sequence succeeded.
    assign skip_req = (mode_sel == current_mode) && !error;

    assign n_entry = N_TABLE[int'(mode_q)*18 +: 18];
    assign m_entry = M_TABLE[int'(mode_q)*18 +: 18];
    assign c_entry = C_TABLE[(int'(mode_q)*NUM_CLOCKS + int'(clk_idx))*18 +: 18];

`ifdef PLL_RECONFIG_LOCK_RETRY_EN
    logic [2:0] rst_cnt;
    logic       retried;
    assign pll_rst = (state == S_RESET_PLL);
`else
    assign pll_rst = 1'b0;
`endif

    always_ff @(posedge refclk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d        = state;
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        case (state)
            S_IDLE:
                if (mode_req && !bad_mode && !skip_req) state_d = S_WR_MODE;
            S_WR_MODE: begin
                mgmt_write = 1'b1; mgmt_address = 6'h00; mgmt_writedata = 32'h1;
                if (xfer) state_d = S_WR_N;
            end
            S_WR_N: begin
                mgmt_write = 1'b1; mgmt_address = 6'h03; mgmt_writedata = {14'b0, n_entry};
                if (xfer) state_d = S_WR_M;
            end
            S_WR_M: begin
                mgmt_write = 1'b1; mgmt_address = 6'h04; mgmt_writedata = {14'b0, m_entry};
                if (xfer) state_d = S_WR_C;
            end
            S_WR_C: begin
                mgmt_write = 1'b1; mgmt_address = 6'h05;
                mgmt_writedata = {9'b0, clk_idx, c_entry};
                if (xfer && last_clk) state_d = S_WR_START;
            end
            S_WR_START: begin
                mgmt_write = 1'b1; mgmt_address = 6'h02; mgmt_writedata = 32'h1;
                if (xfer) state_d = S_POLL;
            end
            S_POLL: begin
                mgmt_read = 1'b1; mgmt_address = 6'h01;
                if (xfer && mgmt_readdata[0]) state_d = S_WAIT_LOCK;
                else if (tmo_exp)             state_d = S_FAIL;
            end
            S_WAIT_LOCK: begin
                if (lock_ok) state_d = S_OK;
`ifdef PLL_RECONFIG_LOCK_RETRY_EN
                else if (tmo_exp) state_d = retried ? S_FAIL : S_RESET_PLL;
`else
                else if (tmo_exp) state_d = S_FAIL;
`endif
            end
`ifdef PLL_RECONFIG_LOCK_RETRY_EN
            S_RESET_PLL:
                if (rst_cnt == 3'd7) state_d = S_WAIT_LOCK;
`endif
            S_OK:    state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            current_mode <= '0;
            mode_q       <= '0;
            clk_idx      <= '0;
            tmo_cnt      <= '0;
            stab_cnt     <= '0;
        end else begin
            done <= 1'b0;

            // Saturating timeout, restarted on every state change.
            if (state_d != state)   tmo_cnt <= '0;
            else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 17'd1;

            if (state == S_WAIT_LOCK && pll_locked) stab_cnt <= stab_cnt + SW'(1);
            else                                    stab_cnt <= '0;

            if (state == S_WR_C) begin
                if (xfer) clk_idx <= clk_idx + 5'd1;
            end else begin
                clk_idx <= '0;
            end

            if (state == S_IDLE && mode_req) begin
                if (bad_mode) begin
                    error <= 1'b1;
                    done  <= 1'b1;
                end else if (skip_req) begin
                    done  <= 1'b1;
                end else begin
                    mode_q <= mode_sel;
                    busy   <= 1'b1;
                end
            end

            if (state == S_OK) begin
                current_mode <= mode_q;
                error        <= 1'b0;
                done         <= 1'b1;
                busy         <= 1'b0;
            end
            if (state == S_FAIL) begin
                error <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end

`ifdef PLL_RECONFIG_LOCK_RETRY_EN
    // One PLL reset per sequence; the flag clears back in IDLE.
    always_ff @(posedge refclk) begin
        if (rst) begin
            rst_cnt <= '0;
            retried <= 1'b0;
        end else begin
            rst_cnt <= (state == S_RESET_PLL) ? rst_cnt + 3'd1 : 3'd0;
            if (state == S_IDLE)               retried <= 1'b0;
            else if (state_d == S_RESET_PLL)   retried <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
module tb_pll_reconfig_sequencer;
    localparam int NM = 3, NC = 2, TMO = 200, LS = 16;
    localparam logic [NM*18-1:0]    N_T = {18'h00101, 18'h20302, 18'h20302};
    localparam logic [NM*18-1:0]    M_T = {18'h01616, 18'h01414, 18'h01212};
    localparam logic [NM*NC*18-1:0] C_T = {18'h00808, 18'h20504, 18'h00101, 18'h00202,
                                           18'h00303, 18'h00202};

    logic        refclk = 1'b0, rst = 1'b1, mode_req = 1'b0, pll_locked = 1'b1;
    logic [1:0]  mode_sel = '0;
    logic        busy, done, error, pll_rst, mgmt_write, mgmt_read;
    logic [1:0]  current_mode;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;

    pll_reconfig_sequencer #(
        .NUM_MODES(NM), .NUM_CLOCKS(NC), .N_TABLE(N_T), .M_TABLE(M_T), .C_TABLE(C_T),
        .LOCK_STABLE(LS), .TIMEOUT(TMO)
    ) dut (
        .refclk(refclk), .rst(rst), .mode_sel(mode_sel), .mode_req(mode_req),
        .pll_locked(pll_locked), .busy(busy), .done(done), .error(error),
        .current_mode(current_mode), .pll_rst(pll_rst), .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read), .mgmt_writedata(mgmt_writedata),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest)
    );

    always #10 refclk = ~refclk;

    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_rd_cyc = 0, strobe_cnt = 0;
    int rd_cnt = 0, poll_zeros = 0, m_wr_cnt = 0, stall_m_cyc = 0, prst_cyc = 0;
    int lock_mode = 0, lock_t = 0, lock_low = 0, stall_left = 0;
    bit rand_wait = 0, stall_m_en = 0, stalled = 0, exp_done = 0, exp_err = 0;
    int mdl_mode = 0;
    bit mdl_err = 0;
    logic [1:0]  exp_mode = '0;
    logic [37:0] exp_wr[$];
    logic [37:0] wr_log[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model tables, written independently of the packed DUT parameters.
    function automatic logic [17:0] n_of(int m);
        case (m) 0: return 18'h20302; 1: return 18'h20302; default: return 18'h00101; endcase
    endfunction
    function automatic logic [17:0] m_of(int m);
        case (m) 0: return 18'h01212; 1: return 18'h01414; default: return 18'h01616; endcase
    endfunction
    function automatic logic [17:0] c_of(int m, int k);
        case (m*2 + k)
            0: return 18'h00202; 1: return 18'h00303;
            2: return 18'h00202; 3: return 18'h00101;
            4: return 18'h20504; default: return 18'h00808;
        endcase
    endfunction

    task automatic push_seq(int m);
        exp_wr.push_back({6'h00, 32'h1});
        exp_wr.push_back({6'h03, 14'b0, n_of(m)});
        exp_wr.push_back({6'h04, 14'b0, m_of(m)});
        for (int k = 0; k < NC; k++)
            exp_wr.push_back({6'h05, 32'(k) << 18 | {14'b0, c_of(m, k)}});
        exp_wr.push_back({6'h02, 32'h1});
    endtask

    // Slave/environment driver: changes inputs just after the rising edge.
    always @(posedge refclk) begin
        #1;
        if (stall_m_en && !stalled && mgmt_write && mgmt_address == 6'h04) begin
            stall_left = 5;
            stalled    = 1;
        end
        if (stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mgmt_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        lock_t++;
        case (lock_mode)
            1:       pll_locked = ((lock_t / 10) % 2) == 0;
            2:       pll_locked = lock_t >= lock_low;
            default: pll_locked = 1'b1;
        endcase
    end

    // Monitor: samples on the falling edge.
    logic        pv_hold = 0, pv_wr = 0, pv_rd = 0, pv_done = 0;
    logic [5:0]  pv_addr = '0;
    logic [31:0] pv_data = '0;
    always @(negedge refclk) begin
        logic [37:0] e;
        cyc++;
        if (!rst) begin
            if (pv_hold) begin
                chk("hold_strobe", {30'b0, mgmt_write, mgmt_read}, {30'b0, pv_wr, pv_rd});
                chk("hold_addr", {26'b0, mgmt_address}, {26'b0, pv_addr});
                chk("hold_data", mgmt_writedata, pv_data);
            end
            if (pv_done) chk("done_one_cycle", {31'b0, done}, 32'd0);
            if (mgmt_write || mgmt_read) begin
                strobe_cnt++;
                chk("one_strobe", {31'b0, mgmt_write & mgmt_read}, 32'd0);
            end
            if (mgmt_write && mgmt_waitrequest && mgmt_address == 6'h04) stall_m_cyc++;
            if (mgmt_write && !mgmt_waitrequest) begin
                wr_log.push_back({mgmt_address, mgmt_writedata});
                if (mgmt_address == 6'h04) m_wr_cnt++;
                chk("write_expected", {31'b0, exp_wr.size() != 0}, 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {26'b0, mgmt_address}, {26'b0, e[37:32]});
                    chk("wr_data", mgmt_writedata, e[31:0]);
                end
            end
            if (mgmt_read && !mgmt_waitrequest) begin
                chk("rd_addr", {26'b0, mgmt_address}, 32'd1);
                mgmt_readdata = {$urandom_range(0, 32767), 16'h0, 1'b0, rd_cnt >= poll_zeros};
                rd_cnt++;
                last_rd_cyc = cyc;
            end else if (mgmt_read) begin
                mgmt_readdata = $urandom;
            end
`ifdef PLL_RECONFIG_LOCK_RETRY_EN
            if (pll_rst) prst_cyc++;
`else
            chk("pll_rst_low", {31'b0, pll_rst}, 32'd0);
`endif
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_expected", {31'b0, exp_done}, 32'd1);
                chk("done_error", {31'b0, error}, {31'b0, exp_err});
                chk("done_mode", {30'b0, current_mode}, {30'b0, exp_mode});
                chk("done_busy", {31'b0, busy}, 32'd0);
                chk("done_writes_left", exp_wr.size(), 32'd0);
            end
            pv_hold = (mgmt_write | mgmt_read) & mgmt_waitrequest;
            pv_wr = mgmt_write; pv_rd = mgmt_read;
            pv_addr = mgmt_address; pv_data = mgmt_writedata; pv_done = done;
        end else begin
            pv_hold = 0;
            pv_done = 0;
        end
    end

    task automatic cycle();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_done(int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            cycle();
            n++;
        end
        chk("done_within_budget", {31'b0, done_cnt != start}, 32'd1);
    endtask

    // Issue one request, predicting its outcome from the model state.
    task automatic issue(int m, bit fail_exp);
        bit reprog;
        int req_cyc, base;
        wr_log.delete();
        rd_cnt = 0; m_wr_cnt = 0; stall_m_cyc = 0; stalled = 0; lock_t = 0; prst_cyc = 0;
        base = strobe_cnt;
        if (m >= NM) begin
            reprog = 0; mdl_err = 1;
        end else if (m == mdl_mode && !mdl_err) begin
            reprog = 0;
        end else begin
            reprog = 1;
            push_seq(m);
            if (fail_exp) mdl_err = 1;
            else begin mdl_err = 0; mdl_mode = m; end
        end
        exp_err = mdl_err; exp_mode = 2'(mdl_mode); exp_done = 1;
        req_cyc = cyc;
        mode_sel = 2'(m); mode_req = 1'b1;
        cycle();
        mode_req = 1'b0;
        chk("busy_after_req", {31'b0, busy}, {31'b0, reprog});
        wait_done(TMO * 3);
        exp_done = 0;
        if (!reprog) begin
            chk("imm_done_latency", done_cyc - req_cyc, 32'd2);
            chk("imm_no_traffic", strobe_cnt - base, 32'd0);
        end else begin
            chk("writes_total", wr_log.size(), 32'(4 + NC));
        end
        chk("busy_idle_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [37:0] lit[6];
        int n, m;
        // Reset state
        repeat (3) cycle();
        chk("rst_busy", {31'b0, busy}, 0);   chk("rst_done", {31'b0, done}, 0);
        chk("rst_error", {31'b0, error}, 0); chk("rst_mode", {30'b0, current_mode}, 0);
        chk("rst_write", {31'b0, mgmt_write}, 0); chk("rst_read", {31'b0, mgmt_read}, 0);
        chk("rst_addr", {26'b0, mgmt_address}, 0); chk("rst_wdata", mgmt_writedata, 0);
        chk("rst_pll_rst", {31'b0, pll_rst}, 0);
        rst = 1'b0;
        repeat (5) cycle();
        chk("no_seq_after_reset", strobe_cnt, 0);

        // Mode 1, three busy polls, lock steady: pinned literal write sequence.
        poll_zeros = 3;
        issue(1, 0);
        lit = '{{6'h00, 32'h1}, {6'h03, 32'h20302}, {6'h04, 32'h01414},
                {6'h05, 32'h00202}, {6'h05, 32'h40101}, {6'h02, 32'h1}};
        for (int i = 0; i < 6; i++)
            chk("lit_write", wr_log.size() > i ? wr_log[i][31:0] : 32'hdead, lit[i][31:0]);
        for (int i = 0; i < 6; i++)
            chk("lit_addr", wr_log.size() > i ? 32'(wr_log[i][37:32]) : 32'hdead,
                32'(lit[i][37:32]));
        chk("lit_reads", rd_cnt, 4);
        chk("lit_mode", {30'b0, current_mode}, 1);
        chk("lit_error", {31'b0, error}, 0);
        n = done_cyc - last_rd_cyc;
        chk("lock_latency_window", {31'b0, n >= LS && n <= LS + 3}, 1);

        // Five waitrequest cycles on the M write.
        poll_zeros = 0; stall_m_en = 1;
        issue(2, 0);
        stall_m_en = 0;
        chk("m_stall_cycles", stall_m_cyc, 5);
        chk("m_write_once", m_wr_cnt, 1);
        chk("m_stall_mode", {30'b0, current_mode}, 2);

        // Same mode with no error: immediate done.
        issue(2, 0);
        // Out-of-range mode.
        issue(3, 0);
        chk("bad_mode_error", {31'b0, error}, 1);
        // After an error the current mode is reprogrammed.
        issue(2, 0);
        chk("reprog_clears_error", {31'b0, error}, 0);

        // Reset during the C writes.
        m = 1;
        push_seq(m);
        exp_done = 1;
        mode_sel = 2'(m); mode_req = 1'b1;
        cycle();
        mode_req = 1'b0;
        n = 0;
        while (!(mgmt_write && mgmt_address == 6'h05) && n < 40) begin cycle(); n++; end
        chk("reached_wr_c", {31'b0, mgmt_write && mgmt_address == 6'h05}, 1);
        rst = 1'b1;
        cycle();
        chk("midrst_write", {31'b0, mgmt_write}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_mode", {30'b0, current_mode}, 0);
        rst = 1'b0;
        exp_wr.delete(); exp_done = 0; mdl_mode = 0; mdl_err = 0;
        n = strobe_cnt;
        repeat (4) cycle();
        chk("midrst_quiet", strobe_cnt - n, 0);

        // Lock toggling every 10 cycles: timeout failure.
        lock_mode = 1;
        issue(1, 1);
        n = done_cyc - last_rd_cyc;
        chk("timeout_window", {31'b0, n >= TMO && n <= TMO + 3}, 1);
        chk("timeout_error", {31'b0, error}, 1);
        chk("timeout_mode", {30'b0, current_mode}, 0);
        // Same mode again reissues the full sequence.
        lock_mode = 0;
        issue(1, 0);
        chk("retry_same_mode", {30'b0, current_mode}, 1);

        // Randomised requests with bus stalls, poll delays and late lock.
        rand_wait = 1; lock_mode = 2;
        for (int i = 0; i < 14; i++) begin
            poll_zeros = $urandom_range(0, 4);
            lock_low = $urandom_range(0, 40);
            issue($urandom_range(0, 3), 0);
        end
        rand_wait = 0;

`ifdef PLL_RECONFIG_LOCK_RETRY_EN
        // Lock arrives only after a timeout: one PLL reset, then success.
        lock_mode = 2; lock_low = 250; poll_zeros = 0;
        issue((mdl_mode + 1) % NM, 0);
        chk("pll_rst_cycles", prst_cyc, 8);
        chk("retry_error", {31'b0, error}, 0);
        lock_mode = 0;
`endif

        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
